// File: rtl/sar_busca4_if.sv
// Signal bundle between the successive-approximation initiator and its comparator/host side.
// master: the SAR initiator. slave: the comparator plus whoever issues start.
interface sar_busca4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             igual;
    logic             maior;
    logic             menor;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, igual, maior, menor,
        output Y, busy, done, result, err
    );

    modport slave (
        output start, igual, maior, menor,
        input  Y, busy, done, result, err
    );
endinterface

// File: rtl/sar_busca4.sv
// Purpose: MSB-first successive-approximation search of a comparator's hidden operand X.
// Latency: start edge to done high is at most WIDTH+1 edges (2 with igual early exit).
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
// Build option: define SAR_EARLY_EXIT_EN to end the search as soon as igual is seen.
module sar_busca4 #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    sar_busca4_if.master  bus
);
    localparam int              IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] Y_MSB   = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] y_q, y_nxt;
    logic [IW-1:0]    idx_q, idx_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;
    logic             err_q, err_nxt;

    logic             one_hot;
    logic             early_hit;
    logic [WIDTH-1:0] y_dec;
    logic [IW-1:0]    idx_m1;

`ifdef SAR_EARLY_EXIT_EN
    assign early_hit = bus.igual;
`else
    assign early_hit = 1'b0;
`endif

    always_comb begin
        one_hot = 1'b0;
        case ({bus.igual, bus.maior, bus.menor})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
    end

    // Bit under test is kept on maior (and on igual), cleared on menor.
    always_comb begin
        y_dec = y_q;
        if (bus.menor) begin
            y_dec[idx_q] = 1'b0;
        end
        idx_m1 = idx_q - 1'b1;
    end

    always_comb begin
        state_nxt  = state_q;
        y_nxt      = y_q;
        idx_nxt    = idx_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        result_nxt = result_q;
        err_nxt    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = TEST;
                    y_nxt     = Y_MSB;
                    idx_nxt   = IDX_TOP;
                    busy_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                end
            end
            TEST: begin
                if (!one_hot || early_hit || idx_q == '0) begin
                    // Y is parked at zero on the way out so it already reads 0 in DONE/IDLE.
                    state_nxt  = DONE;
                    y_nxt      = '0;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    err_nxt    = !one_hot;
                    result_nxt = !one_hot ? '0 : (early_hit ? y_q : y_dec);
                end else begin
                    y_nxt         = y_dec;
                    y_nxt[idx_m1] = 1'b1;
                    idx_nxt       = idx_m1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                y_nxt     = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            y_q      <= '0;
            idx_q    <= IDX_TOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            y_q      <= y_nxt;
            idx_q    <= idx_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            result_q <= result_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.Y      = y_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_busca4.sv
// Bench for sar_busca4: a comparator with a hidden X answers the DUT's guesses, and an
// arithmetic model of binary search predicts every guess, the result and the error flag.
module tb_sar_busca4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    int         hidden_x  = 0;
    bit         force_en  = 1'b0;
    logic [2:0] force_val = 3'b000;
    int         exp_y[$];
    int         exp_res;
    int         exp_err;

    sar_busca4_if #(.WIDTH(W)) bus ();

    sar_busca4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.igual = force_en ? force_val[2] : (hidden_x == int'(bus.Y));
    assign bus.maior = force_en ? force_val[1] : (hidden_x >  int'(bus.Y));
    assign bus.menor = force_en ? force_val[0] : (hidden_x <  int'(bus.Y));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Binary search over the value range: try each bit from the top, keep it if X is not below the guess.
    task automatic model(input int x, input bit forced);
        int prefix;
        int guess;
        exp_y.delete();
        if (forced) begin
            exp_y.push_back(1 << (W - 1));
            exp_res = 0;
            exp_err = 1;
        end else begin
            prefix = 0;
            for (int i = W - 1; i >= 0; i--) begin
                guess = prefix + (1 << i);
                exp_y.push_back(guess);
`ifdef SAR_EARLY_EXIT_EN
                if (guess == x) break;
`endif
                if (x >= guess) prefix = guess;
            end
            exp_res = x;
            exp_err = 0;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_search(input int x, input bit forced, input logic [2:0] fv, input bit hold);
        hidden_x  = x;
        force_en  = forced;
        force_val = fv;
        model(x, forced);
        bus.start = 1'b1;
        for (int k = 0; k < exp_y.size(); k++) begin
            @(negedge clk);
            bus.start = hold ? 1'b1 : 1'(($urandom_range(0, 1)));
            chk("test_busy", 32'(bus.busy), 32'd1);
            chk("test_done", 32'(bus.done), 32'd0);
            chk("test_y", 32'(bus.Y), 32'(exp_y[k]));
        end
        @(negedge clk);
        bus.start = hold;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_result", 32'(bus.result), 32'(exp_res));
        chk("done_err", 32'(bus.err), 32'(exp_err));
        chk("done_y", 32'(bus.Y), 32'd0);
        @(negedge clk);
        force_en = 1'b0;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_y", 32'(bus.Y), 32'd0);
        chk("idle_result", 32'(bus.result), 32'(exp_res));
        chk("idle_err", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic chk_reset_vals();
        chk("rst_y", 32'(bus.Y), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        run_search(0, 1'b0, 3'b000, 1'b0);
        run_search(15, 1'b0, 3'b000, 1'b0);
        run_search(5, 1'b0, 3'b000, 1'b0);
        run_search(8, 1'b0, 3'b000, 1'b0);

        run_search(9, 1'b1, 3'b000, 1'b0);
        run_search(3, 1'b1, 3'b110, 1'b0);
        // A clean search after an error must clear err.
        run_search(11, 1'b0, 3'b000, 1'b0);

        // start held high through DONE restarts on the first IDLE cycle.
        run_search(6, 1'b0, 3'b000, 1'b1);
        run_search(13, 1'b0, 3'b000, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0, 3'b000, 1'($urandom_range(0, 1)));
        end

        // Reset during the second TEST cycle: back to reset values, no done pulse.
        hidden_x = int'($urandom_range(0, (1 << W) - 1));
        model(hidden_x, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_y0", 32'(bus.Y), 32'(exp_y[0]));
        @(negedge clk);
        chk("mid_y1", 32'(bus.Y), 32'(exp_y[1]));
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(bus.done), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        run_search(7, 1'b0, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
